// File: rtl/clock_monitor.sv
// clock_monitor: measures the period and high time of async `in` on `clock`, checks both against EXP_* +/- TOL, flags a stalled input.
// Edge detect takes 3 edges; results land one cycle after the closing rise; no backpressure. `CLKMON_STICKY_ERR_EN adds err_clr/sticky_err.
module clock_monitor #(
    parameter int CNT_W      = 16,
    parameter int EXP_PERIOD = 4,
    parameter int EXP_HIGH   = 1,
    parameter int TOL        = 0,
    parameter int TIMEOUT    = 1024
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             in,
`ifdef CLKMON_STICKY_ERR_EN
    input  logic             err_clr,
    output logic             sticky_err,
`endif
    output logic [CNT_W-1:0] period,
    output logic [CNT_W-1:0] high_time,
    output logic             meas_valid,
    output logic             freq_ok,
    output logic             duty_ok,
    output logic             lost
);
    localparam int                IDLE_W   = $clog2(TIMEOUT);
    localparam logic [IDLE_W-1:0] IDLE_MAX = IDLE_W'(TIMEOUT - 1);
    localparam logic [CNT_W-1:0]  CNT_MAX  = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0]  EXP_P    = CNT_W'(EXP_PERIOD);
    localparam logic [CNT_W-1:0]  EXP_H    = CNT_W'(EXP_HIGH);
    localparam logic [CNT_W-1:0]  TOL_V    = CNT_W'(TOL);

    typedef enum logic [1:0] {S_IDLE, S_HIGH, S_LOW} state_t;

    state_t            state_q, state_d;
    logic              sync1_q, sync2_q, s_prev_q;
    logic              rise, fall, any_edge, timeout, meas;
    logic [CNT_W-1:0]  high_cnt_q, high_cnt_d;
    logic [CNT_W-1:0]  low_cnt_q, low_cnt_d;
    logic [CNT_W-1:0]  period_q, period_d;
    logic [CNT_W-1:0]  high_time_q, high_time_d;
    logic [CNT_W:0]    sum;
    logic [IDLE_W-1:0] idle_cnt_q, idle_cnt_d;
    logic              meas_valid_q, meas_valid_d;
    logic              freq_ok_q, freq_ok_d;
    logic              duty_ok_q, duty_ok_d;
    logic              lost_q, lost_d;

    function automatic logic within_tol(input logic [CNT_W-1:0] v, input logic [CNT_W-1:0] e);
        logic [CNT_W-1:0] diff;
        diff = (v >= e) ? (v - e) : (e - v);
        return diff <= TOL_V;
    endfunction

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            sync1_q  <= 1'b0;
            sync2_q  <= 1'b0;
            s_prev_q <= 1'b0;
        end else begin
            sync1_q  <= in;
            sync2_q  <= sync1_q;
            s_prev_q <= sync2_q;
        end
    end

    assign rise     = sync2_q & ~s_prev_q;
    assign fall     = ~sync2_q & s_prev_q;
    assign any_edge = rise | fall;
    // A detected edge in the timeout cycle keeps the input alive.
    assign timeout  = ~any_edge & (idle_cnt_q == IDLE_MAX);
    assign meas     = (state_q == S_LOW) & rise;
    assign sum      = {1'b0, high_cnt_q} + {1'b0, low_cnt_q};

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) state_q <= S_IDLE;
        else          state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        if (timeout) begin
            state_d = S_IDLE;
        end else begin
            case (state_q)
                S_IDLE:  if (rise) state_d = S_HIGH;
                S_HIGH:  if (fall) state_d = S_LOW;
                S_LOW:   if (rise) state_d = S_HIGH;
                default: state_d = S_IDLE;
            endcase
        end
    end

    always_comb begin
        high_cnt_d   = high_cnt_q;
        low_cnt_d    = low_cnt_q;
        period_d     = period_q;
        high_time_d  = high_time_q;
        freq_ok_d    = freq_ok_q;
        duty_ok_d    = duty_ok_q;
        lost_d       = lost_q;
        meas_valid_d = meas;
        idle_cnt_d   = any_edge ? '0 :
                       (idle_cnt_q == IDLE_MAX) ? idle_cnt_q : idle_cnt_q + IDLE_W'(1);
        case (state_q)
            S_IDLE: begin
                if (rise) begin
                    high_cnt_d = CNT_W'(1);
                    low_cnt_d  = '0;
                end
            end
            S_HIGH: begin
                if (fall)                       low_cnt_d  = CNT_W'(1);
                else if (high_cnt_q != CNT_MAX) high_cnt_d = high_cnt_q + CNT_W'(1);
            end
            S_LOW: begin
                if (rise) begin
                    period_d    = sum[CNT_W] ? CNT_MAX : sum[CNT_W-1:0];
                    high_time_d = high_cnt_q;
                    freq_ok_d   = within_tol(period_d, EXP_P);
                    duty_ok_d   = within_tol(high_cnt_q, EXP_H);
                    high_cnt_d  = CNT_W'(1);
                    low_cnt_d   = '0;
                end else if (low_cnt_q != CNT_MAX) begin
                    low_cnt_d = low_cnt_q + CNT_W'(1);
                end
            end
            default: ;
        endcase
        if (rise) lost_d = 1'b0;
        // Measurements already taken are kept for inspection; only the verdicts drop.
        if (timeout) begin
            lost_d    = 1'b1;
            freq_ok_d = 1'b0;
            duty_ok_d = 1'b0;
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            high_cnt_q   <= '0;
            low_cnt_q    <= '0;
            period_q     <= '0;
            high_time_q  <= '0;
            idle_cnt_q   <= '0;
            meas_valid_q <= 1'b0;
            freq_ok_q    <= 1'b0;
            duty_ok_q    <= 1'b0;
            lost_q       <= 1'b0;
        end else begin
            high_cnt_q   <= high_cnt_d;
            low_cnt_q    <= low_cnt_d;
            period_q     <= period_d;
            high_time_q  <= high_time_d;
            idle_cnt_q   <= idle_cnt_d;
            meas_valid_q <= meas_valid_d;
            freq_ok_q    <= freq_ok_d;
            duty_ok_q    <= duty_ok_d;
            lost_q       <= lost_d;
        end
    end

`ifdef CLKMON_STICKY_ERR_EN
    logic sticky_q, sticky_d;

    // Set takes priority over clear so a coincident error is never dropped.
    always_comb begin
        sticky_d = sticky_q;
        if (err_clr) sticky_d = 1'b0;
        if ((meas_valid_q && !(freq_ok_q && duty_ok_q)) || (lost_d && !lost_q)) sticky_d = 1'b1;
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) sticky_q <= 1'b0;
        else          sticky_q <= sticky_d;
    end

    assign sticky_err = sticky_q;
`endif

    assign period     = period_q;
    assign high_time  = high_time_q;
    assign meas_valid = meas_valid_q;
    assign freq_ok    = freq_ok_q;
    assign duty_ok    = duty_ok_q;
    assign lost       = lost_q;

endmodule

// File: doc/clock_monitor.md
Name: clock_monitor

Overview:
- Receive-side checker for generated clocks: samples an asynchronous clock-like signal `in` on the system `clock`.
- Measures the period and high time of `in` in system-clock cycles.
- Checks both measurements against expected values within a tolerance, and flags a lost (stalled) input.
- Sits beside clock generators to verify frequency and duty cycle in-system, e.g. a 25 MHz / 25 % signal sampled at 100 MHz gives period 4, high 1.

Parameters:
- CNT_W, 16, width of period/high-time counters and outputs.
- EXP_PERIOD, 4, expected period of `in` in `clock` cycles.
- EXP_HIGH, 1, expected high time of `in` in `clock` cycles.
- TOL, 0, allowed absolute deviation (cycles) for both checks.
- TIMEOUT, 1024, cycles without any edge on `in` before `lost` asserts; must be >= 2.

Ports:
- clock  input  1  system sampling clock, all logic on rising edge.
- reset_n  input  1  asynchronous active-low reset.
- in  input  1  monitored signal, asynchronous to `clock`.
- period  output  CNT_W  last measured period (high+low cycles).
- high_time  output  CNT_W  last measured high time.
- meas_valid  output  1  one-cycle pulse when period/high_time/flags update.
- freq_ok  output  1  last period within EXP_PERIOD ± TOL.
- duty_ok  output  1  last high time within EXP_HIGH ± TOL.
- lost  output  1  no edge on `in` for TIMEOUT cycles.

Behaviour:
- Reset (async, reset_n=0):
  - All outputs 0; state IDLE; all counters 0.
  - Synchronizer flops and previous-sample flop 0.
- Input path: 2-flop synchronizer → `s`; register `s_d`.
  - rise = s & ~s_d; fall = ~s & s_d.
  - Latency from `in` edge to detection: 3 `clock` edges.
  - Rise and fall are mutually exclusive by construction.
- FSM states:
  - IDLE: waits for rise; fall ignored. On rise: high_cnt←1, low_cnt←0, go HIGH. No meas_valid.
  - HIGH: no fall → high_cnt += 1 (saturate at all-ones). On fall: low_cnt←1, go LOW.
  - LOW: no rise → low_cnt += 1 (saturate). On rise, all in that cycle:
    - period ← high_cnt + low_cnt, computed at CNT_W+1 bits and saturated to all-ones.
    - high_time ← high_cnt.
    - freq_ok, duty_ok updated; meas_valid pulses the next cycle, aligned with the new values.
    - high_cnt←1, low_cnt←0, go HIGH.
- Check rules:
  - freq_ok = |period − EXP_PERIOD| ≤ TOL; duty_ok = |high_time − EXP_HIGH| ≤ TOL.
  - Unsigned compare, no wrap.
  - Flags hold until the next measurement, lost, or reset.
- Measurement timing: the first measurement after IDLE needs one full period, so the first meas_valid comes at the second detected rise.
- Timeout:
  - idle_cnt clears on any rise/fall, else increments (saturating).
  - When idle_cnt reaches TIMEOUT-1 with no edge: lost←1, freq_ok←0, duty_ok←0, state→IDLE. period/high_time are held.
  - An edge in the same cycle as timeout wins: no lost.
  - lost clears on the first rise detected afterwards.
- Boundaries:
  - Constant `in` from reset → lost after TIMEOUT cycles, no meas_valid.
  - A pulse whose high or low is shorter than 1 `clock` cycle may be missed; this is not an error, and it counts into the surrounding phase.
- Reset mid-measurement: everything returns to reset values immediately; measurement restarts from IDLE.

Optional Feature:
- Macro: CLKMON_STICKY_ERR_EN.
- Defined: adds ports `err_clr` (input, 1) and `sticky_err` (output, 1, reset 0).
  - sticky_err sets on any meas_valid with freq_ok=0 or duty_ok=0, or on lost rising.
  - Cleared by err_clr=1. A set condition in the same cycle as err_clr wins.
- Undefined: ports and logic absent; all other behaviour identical.

Test Plan:
- 25 MHz, 25 % `in` (high 1, low 3 cycles at 100 MHz), defaults:
  - first meas_valid 3 cycles after second rise reaches `in`.
  - period=4, high_time=1, freq_ok=1, duty_ok=1, lost=0.
  - meas_valid repeats every 4 cycles.
- `in` high 2, low 2, TOL=0 → period=4, high_time=2, freq_ok=1, duty_ok=0; with TOL=1 → duty_ok=1.
- `in` held 0 from reset, TIMEOUT=16 → lost=1 at cycle 16, no meas_valid. Then toggle 1/3 pattern → lost clears on first rise; valid measurement one period later.
- Period of 70000 cycles with CNT_W=16 → period=65535 (saturated), freq_ok=0.
- reset_n pulsed low mid-LOW phase → all outputs 0 asynchronously; after release, first meas_valid only after two new rises.
- CLKMON_STICKY_ERR_EN defined:
  - one bad period (6) → sticky_err=1 and stays set through later good periods.
  - err_clr pulse → 0.
  - err_clr coinciding with a bad meas_valid → stays 1.
